// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key schedule
// and the mix-column stages.
package aes_pkg;

    typedef logic [0:127] block_t;
    typedef logic [0:31]  word_t;

    localparam int NR = 10;

    // Round constants, MSB byte of the Rcon word, indexed by round.
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_t;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product built from repeated xtime.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// Combinational InvMixColumns over a 128-bit state (FIPS-197 byte order).
// Only built when AES_KS_EQ_INV_EN is defined.
`ifdef AES_KS_EQ_INV_EN
module aes_inv_mix_columns
    import aes_pkg::*;
(
    input  logic [0:127] data_i,
    output logic [0:127] data_o
);

    logic [7:0] a0, a1, a2, a3;

    // Each column multiplied by the inverse circulant {0e,0b,0d,09}.
    always_comb begin
        data_o = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = data_i[32*c +: 8];
            a1 = data_i[32*c + 8 +: 8];
            a2 = data_i[32*c + 16 +: 8];
            a3 = data_i[32*c + 24 +: 8];
            data_o[32*c +: 8]      = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            data_o[32*c + 8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            data_o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            data_o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    end

endmodule
`endif

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// followed by the FIPS-197 affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse computed as x^254 (maps 0 to 0), then affine transform.
    always_comb begin
        x2    = gf_mul(in_i, in_i);
        x3    = gf_mul(x2, in_i);
        x6    = gf_mul(x3, x3);
        x12   = gf_mul(x6, x6);
        x15   = gf_mul(x12, x3);
        x30   = gf_mul(x15, x15);
        x60   = gf_mul(x30, x30);
        x120  = gf_mul(x60, x60);
        x240  = gf_mul(x120, x120);
        x252  = gf_mul(x240, x12);
        inv   = gf_mul(x252, x2);
        out_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes128_key_schedule.sv
// Sequential AES-128 key expansion (one round per clock) with an indexed,
// registered round-key read port for the inverse cipher.
// Optional macro AES_KS_EQ_INV_EN adds rk_eq (equivalent-inverse-cipher keys).
module aes128_key_schedule #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:127]     key,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    input  logic             rk_req,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [0:127]     rk_out,
    output logic             rk_out_valid
`ifdef AES_KS_EQ_INV_EN
   ,output logic [0:127]     rk_eq
`endif
);
    import aes_pkg::*;

    localparam logic [3:0]       LAST_ROUND = 4'(NR);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NR);

    ks_state_t  state_q, state_d;
    logic [3:0] round_q, round_d;
    block_t     rk_q [0:NR];

    logic   accept;
    block_t prev_rk, next_rk;
    word_t  w0, w1, w2, w3, rot_w, sub_w, n0, n1, n2, n3;
    logic [7:0] rcon;
    logic   rd_hit;
    block_t sel_rk;

    assign key_ready  = (state_q != EXPAND);
    assign busy       = (state_q == EXPAND);
    assign keys_valid = (state_q == READY);
    assign accept     = key_valid && key_ready;

    // One FIPS-197 round of the key expansion from the previous round key.
    always_comb begin
        prev_rk = rk_q[round_q - 4'd1];
        w0      = prev_rk[0:31];
        w1      = prev_rk[32:63];
        w2      = prev_rk[64:95];
        w3      = prev_rk[96:127];
        rot_w   = {w3[8:31], w3[0:7]};
        rcon    = (round_q >= 4'd1 && round_q <= LAST_ROUND) ? aes_pkg::RCON[round_q] : 8'h00;
        n0      = w0 ^ sub_w ^ {rcon, 24'h000000};
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        next_rk = {n0, n1, n2, n3};
    end

    aes_sbox u_sbox0 (.in_i(rot_w[0:7]),   .out_o(sub_w[0:7]));
    aes_sbox u_sbox1 (.in_i(rot_w[8:15]),  .out_o(sub_w[8:15]));
    aes_sbox u_sbox2 (.in_i(rot_w[16:23]), .out_o(sub_w[16:23]));
    aes_sbox u_sbox3 (.in_i(rot_w[24:31]), .out_o(sub_w[24:31]));

    // Next-state and round-counter logic.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            IDLE, READY: begin
                if (accept) begin
                    state_d = EXPAND;
                    round_d = 4'd1;
                end
            end
            EXPAND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = READY;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Round-key storage; not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                rk_q[0] <= key;
            end else if (state_q == EXPAND) begin
                rk_q[round_q] <= next_rk;
            end
        end
    end

    // Read selection uses pre-edge storage, so a read coinciding with a new
    // accept still returns the old key set.
    always_comb begin
        rd_hit = keys_valid && (rk_idx <= LAST_IDX);
        sel_rk = rd_hit ? rk_q[rk_idx] : '0;
    end

`ifdef AES_KS_EQ_INV_EN
    block_t sel_imc, sel_eq;

    aes_inv_mix_columns u_imc (.data_i(sel_rk), .data_o(sel_imc));

    // First and last round keys pass through unchanged.
    always_comb begin
        sel_eq = (rk_idx == '0 || rk_idx == LAST_IDX) ? sel_rk : sel_imc;
    end
`endif

    // Registered read port: one-cycle latency, output holds without a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out       <= '0;
            rk_out_valid <= 1'b0;
`ifdef AES_KS_EQ_INV_EN
            rk_eq        <= '0;
`endif
        end else begin
            rk_out_valid <= rk_req;
            if (rk_req) begin
                rk_out <= sel_rk;
`ifdef AES_KS_EQ_INV_EN
                rk_eq  <= sel_eq;
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Self-checking bench for aes128_key_schedule against a word-level
// FIPS-197 key-expansion model with a table-built S-box.
module tb_aes128_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:127] key;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [0:127] rk_out;
    logic         rk_out_valid;
`ifdef AES_KS_EQ_INV_EN
    logic [0:127] rk_eq;
`endif

    always #5 clk = ~clk;

    aes128_key_schedule #(.NR(10), .IDX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .busy         (busy),
        .keys_valid   (keys_valid),
        .rk_req       (rk_req),
        .rk_idx       (rk_idx),
        .rk_out       (rk_out),
        .rk_out_valid (rk_out_valid)
`ifdef AES_KS_EQ_INV_EN
       ,.rk_eq        (rk_eq)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sb [256];
    logic [127:0] model_rk [11];
    bit           model_ok = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] exp_rk(input int idx);
        return (model_ok && idx <= 10) ? model_rk[idx] : 128'h0;
    endfunction

`ifdef AES_KS_EQ_INV_EN
    function automatic logic [127:0] imc(input logic [127:0] v);
        logic [7:0]   coef [4];
        logic [7:0]   b;
        logic [127:0] r;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(coef[(j - row + 4) % 4], v[127 - 8*(4*c + j) -: 8]);
                r[127 - 8*(4*c + row) -: 8] = b;
            end
        return r;
    endfunction

    function automatic logic [127:0] exp_eq(input int idx);
        if (!(model_ok && idx <= 10)) return 128'h0;
        if (idx == 0 || idx == 10) return model_rk[idx];
        return imc(model_rk[idx]);
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string tag, input int idx);
        check({tag, " rk_out"}, rk_out, exp_rk(idx));
        check({tag, " valid"}, {127'h0, rk_out_valid}, 128'h1);
`ifdef AES_KS_EQ_INV_EN
        check({tag, " rk_eq"}, rk_eq, exp_eq(idx));
`endif
    endtask

    task automatic read_idx(input string tag, input int idx);
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        tick();
        rk_req = 1'b0;
        check_read(tag, idx);
    endtask

    task automatic wait_keys(input string tag);
        int n;
        n = 0;
        while (keys_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " keys_valid timeout"}, {127'h0, n < 20}, 128'h1);
    endtask

    task automatic load_key(input string tag, input logic [127:0] k);
        int n;
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        model_ok  = 1'b0;
        n = 0;
        while (keys_valid !== 1'b1 && n < 20) begin
            check({tag, " busy"}, {127'h0, busy}, 128'h1);
            tick();
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'd10);
        check({tag, " busy after"}, {127'h0, busy}, 128'h0);
        expand_model(k);
        model_ok = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k1, k2, k3;
        build_sbox();
        rst = 1'b1; key = '0; key_valid = 1'b0; rk_req = 1'b0; rk_idx = '0;
        tick();
        tick();
        check("rst key_ready", {127'h0, key_ready}, 128'h1);
        check("rst busy", {127'h0, busy}, 128'h0);
        check("rst keys_valid", {127'h0, keys_valid}, 128'h0);
        check("rst rk_out", rk_out, 128'h0);
        check("rst rk_out_valid", {127'h0, rk_out_valid}, 128'h0);
        rst = 1'b0;
        tick();
        read_idx("idle read", 3);

        load_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_idx("fips r1", 1);
        check("fips r1 const", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
        read_idx("fips r10", 10);
        check("fips r10 const", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        load_key("zero", 128'h0);
        read_idx("zero r1", 1);
        check("zero r1 const", rk_out, 128'h62636363626363636263636362636363);
        read_idx("zero r10", 10);
        check("zero r10 const", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int t = 0; t < 3; t++) begin
            load_key("rand", {$urandom, $urandom, $urandom, $urandom});
            rk_req = 1'b1;
            for (int idx = 10; idx >= 0; idx--) begin
                rk_idx = 4'(idx);
                tick();
                check_read("sweep", idx);
            end
            rk_req = 1'b0;
            tick();
            check("sweep valid drop", {127'h0, rk_out_valid}, 128'h0);
            check("sweep hold", rk_out, exp_rk(0));
        end

        read_idx("idx 11", 11);
        read_idx("idx 15", 15);

        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        key = k1; key_valid = 1'b1;
        tick();
        model_ok = 1'b0;
        key = k2;
        check("expand key_ready", {127'h0, key_ready}, 128'h0);
        tick();
        check("expand key_ready 2", {127'h0, key_ready}, 128'h0);
        read_idx("expand read", 5);
        key_valid = 1'b0;
        wait_keys("ignore");
        expand_model(k1);
        model_ok = 1'b1;
        read_idx("ignore r10", 10);
        read_idx("ignore r4", 4);

        key = k2; key_valid = 1'b1; rk_req = 1'b1; rk_idx = 4'd10;
        tick();
        key_valid = 1'b0; rk_req = 1'b0;
        check_read("accept+read old", 10);
        check("accept keys_valid drop", {127'h0, keys_valid}, 128'h0);
        model_ok = 1'b0;
        wait_keys("restart");
        expand_model(k2);
        model_ok = 1'b1;
        read_idx("restart r10", 10);

        k3 = {$urandom, $urandom, $urandom, $urandom};
        key = k3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        model_ok = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst keys_valid", {127'h0, keys_valid}, 128'h0);
        check("midrst busy", {127'h0, busy}, 128'h0);
        check("midrst key_ready", {127'h0, key_ready}, 128'h1);
        read_idx("midrst read", 10);
        load_key("post rst", {$urandom, $urandom, $urandom, $urandom});
        read_idx("post rst r10", 10);
        read_idx("post rst r0", 0);
        read_idx("post rst r7", 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
